spi_memory_burst: RTL and testbench

Parametrised SPI-slave memory, successor to the 7-bit-address / 8-bit-data SPI memory. An external SPI master addresses a DEPTH-word on-chip memory through a serial frame. The frame carries an ADDR_WIDTH-bit address, a read/write bit, and any number of DATA_WIDTH-bit words, with the address auto-incrementing (burst mode). The block runs entirely in the system clock domain: SPI pins are oversampled through synchronisers and edge detectors.

---
 rtl/spi_memory_burst.sv | 162 ++++++++++++++++
 tb/tb_spi_memory_burst.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_memory_burst.sv
// SPI-slave (mode 0) memory with auto-incrementing burst access.
// All SPI pins are oversampled in the clk domain; the frame is address, R/W bit, then data words.
module spi_memory_burst #(
   parameter int ADDR_WIDTH  = 7,
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sclk,
   input  logic cs,
   input  logic mosi,
   output logic miso,
   output logic miso_oe,
   output logic frame_done
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int MAXW  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
   localparam int CW    = $clog2(MAXW + 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ADDR  = 3'd1;
   localparam logic [2:0] S_RW    = 3'd2;
   localparam logic [2:0] S_WDATA = 3'd3;
   localparam logic [2:0] S_RDATA = 3'd4;

   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic                   sclk_prev_q, cs_prev_q;
   logic                   sclk_s, cs_s, mosi_s;
   logic                   sample_ev, shift_ev, cs_fall, cs_rise;

   logic [2:0]             state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d, addr_inc;
   logic [DATA_WIDTH-1:0]  sh_q, sh_d, wword;
   logic                   miso_q, miso_d;
   logic                   frame_done_q, frame_done_d;
   logic                   we;

   logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

   // cs synchroniser resets low so a cs already low at reset release is not seen as a frame start
   always_comb begin
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
   end

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign sample_ev = sclk_s & ~sclk_prev_q;
   assign shift_ev  = ~sclk_s & sclk_prev_q;
   assign cs_fall   = ~cs_s & cs_prev_q;
   assign cs_rise   = cs_s & ~cs_prev_q;
   assign addr_inc  = addr_q + 1'b1;
   assign wword     = {sh_q[DATA_WIDTH-2:0], mosi_s};

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      sh_d         = sh_q;
      miso_d       = miso_q;
      frame_done_d = 1'b0;
      we           = 1'b0;
      if (cs_rise) begin
         state_d      = S_IDLE;
         cnt_d        = '0;
         miso_d       = 1'b0;
         frame_done_d = (state_q == S_WDATA) || (state_q == S_RDATA);
      end else begin
         case (state_q)
            S_IDLE: if (cs_fall) begin
               state_d = S_ADDR;
               cnt_d   = '0;
            end
            S_ADDR: if (sample_ev) begin
               addr_d = {addr_q[ADDR_WIDTH-2:0], mosi_s};
               cnt_d  = cnt_q + 1'b1;
               if (cnt_q == CW'(ADDR_WIDTH - 1)) begin
                  state_d = S_RW;
                  cnt_d   = '0;
               end
            end
            S_RW: if (sample_ev) begin
               cnt_d = '0;
               if (mosi_s) begin
                  sh_d    = mem_q[addr_q];
                  state_d = S_RDATA;
               end else begin
                  state_d = S_WDATA;
               end
            end
            S_WDATA: if (sample_ev) begin
               sh_d  = wword;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                  we     = 1'b1;
                  addr_d = addr_inc;
                  cnt_d  = '0;
               end
            end
            S_RDATA: begin
               if (shift_ev) begin
                  miso_d = sh_q[DATA_WIDTH-1];
                  sh_d   = sh_q << 1;
               end
               // next word is fetched on the last sample so its MSB is ready for the following shift
               if (sample_ev) begin
                  cnt_d = cnt_q + 1'b1;
                  if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                     addr_d = addr_inc;
                     sh_d   = mem_q[addr_inc];
                     cnt_d  = '0;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync_q  <= '0;
         cs_sync_q    <= '0;
         mosi_sync_q  <= '0;
         sclk_prev_q  <= 1'b0;
         cs_prev_q    <= 1'b0;
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         addr_q       <= '0;
         sh_q         <= '0;
         miso_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         sclk_sync_q  <= sclk_sync_d;
         cs_sync_q    <= cs_sync_d;
         mosi_sync_q  <= mosi_sync_d;
         sclk_prev_q  <= sclk_s;
         cs_prev_q    <= cs_s;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         sh_q         <= sh_d;
         miso_q       <= miso_d;
         frame_done_q <= frame_done_d;
      end
   end

   always_ff @(posedge clk) begin
      if (we) mem_q[addr_q] <= wword;
   end

   // enable follows the cs pin directly so the line is released as soon as the master deselects
   assign miso_oe    = (state_q == S_RDATA) && !cs;
   assign miso       = miso_oe & miso_q;
   assign frame_done = frame_done_q;
endmodule

// File: tb/tb_spi_memory_burst.sv
// Directed bench for spi_memory_burst: default, wide-data and 3-stage-synchroniser instances.
module tb_spi_memory_burst;
   localparam int PH = 6;

   typedef struct {
      int          id;
      int          aw;
      int          dw;
      int          addr;
      logic        rd;
      int          nw;
      logic [15:0] d [3];
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] sclk_v = 3'b000;
   logic [2:0] cs_v = 3'b111;
   logic [2:0] mosi_v = 3'b000;
   logic       miso0, miso1, miso2, oe0, oe1, oe2, done0, done1, done2;
   logic [2:0] miso_v, oe_v, done_v;

   int errors = 0;
   int checks = 0;
   int done_cnt [3] = '{0, 0, 0};
   int oe_viol = 0;
   int oe_bad;
   logic [15:0] rbuf [3];
   vec_t tbl [12];

   assign miso_v = {miso2, miso1, miso0};
   assign oe_v   = {oe2, oe1, oe0};
   assign done_v = {done2, done1, done0};

   always #5 clk = ~clk;

   spi_memory_burst #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .SYNC_STAGES(2)) u0 (
      .clk(clk), .rst_n(rst_n), .sclk(sclk_v[0]), .cs(cs_v[0]), .mosi(mosi_v[0]),
      .miso(miso0), .miso_oe(oe0), .frame_done(done0));
   spi_memory_burst #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .SYNC_STAGES(2)) u1 (
      .clk(clk), .rst_n(rst_n), .sclk(sclk_v[1]), .cs(cs_v[1]), .mosi(mosi_v[1]),
      .miso(miso1), .miso_oe(oe1), .frame_done(done1));
   spi_memory_burst #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .SYNC_STAGES(3)) u2 (
      .clk(clk), .rst_n(rst_n), .sclk(sclk_v[2]), .cs(cs_v[2]), .mosi(mosi_v[2]),
      .miso(miso2), .miso_oe(oe2), .frame_done(done2));

   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) if (done_v[i] === 1'b1) done_cnt[i] <= done_cnt[i] + 1;
   end

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++)
         if ((cs_v[k] && oe_v[k]) || (!oe_v[k] && miso_v[k])) oe_viol <= oe_viol + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bit_xfer(input int id, input logic b, output logic r, output logic oe);
      mosi_v[id] = b;
      wclk(PH);
      r  = miso_v[id];
      oe = oe_v[id];
      sclk_v[id] = 1'b1;
      wclk(PH);
      sclk_v[id] = 1'b0;
   endtask

   task automatic frame(input vec_t v);
      logic        r, oe;
      logic [15:0] word;
      oe_bad = 0;
      cs_v[v.id] = 1'b0;
      wclk(PH);
      for (int i = v.aw - 1; i >= 0; i--) bit_xfer(v.id, v.addr[i], r, oe);
      bit_xfer(v.id, v.rd, r, oe);
      for (int w = 0; w < v.nw; w++) begin
         word = '0;
         for (int b = v.dw - 1; b >= 0; b--) begin
            bit_xfer(v.id, v.d[w][b], r, oe);
            word[b] = r;
            if (v.rd && oe !== 1'b1) oe_bad++;
         end
         rbuf[w] = word;
      end
      wclk(PH);
      cs_v[v.id] = 1'b1;
      wclk(2 * PH);
   endtask

   function automatic vec_t mk(input int id, input int aw, input int dw, input int addr,
                               input logic rd, input int nw,
                               input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
      vec_t v;
      v.id = id; v.aw = aw; v.dw = dw; v.addr = addr; v.rd = rd; v.nw = nw;
      v.d[0] = a; v.d[1] = b; v.d[2] = c;
      return v;
   endfunction

   task automatic run_vec(input vec_t v, input string tag);
      int d0;
      d0 = done_cnt[v.id];
      frame(v);
      chk({tag, "_done"}, done_cnt[v.id] - d0, 1);
      if (v.rd) begin
         for (int w = 0; w < v.nw; w++) chk({tag, "_word"}, rbuf[w], v.d[w]);
         chk({tag, "_oe"}, oe_bad, 0);
      end
   endtask

   initial begin
      logic r, oe;
      logic [2:0] part;
      int d0;

      tbl[0]  = mk(0, 7, 8,  'h2A, 1'b0, 1, 16'hA5, 16'h0, 16'h0);
      tbl[1]  = mk(0, 7, 8,  'h2A, 1'b1, 1, 16'hA5, 16'h0, 16'h0);
      tbl[2]  = mk(0, 7, 8,  'h7E, 1'b0, 3, 16'h11, 16'h22, 16'h33);
      tbl[3]  = mk(0, 7, 8,  'h7E, 1'b1, 3, 16'h11, 16'h22, 16'h33);
      tbl[4]  = mk(0, 7, 8,  'h00, 1'b1, 1, 16'h33, 16'h0, 16'h0);
      tbl[5]  = mk(0, 7, 8,  'h05, 1'b0, 1, 16'h3C, 16'h0, 16'h0);
      tbl[6]  = mk(1, 4, 16, 'hF,  1'b0, 1, 16'hBEEF, 16'h0, 16'h0);
      tbl[7]  = mk(1, 4, 16, 'hF,  1'b1, 1, 16'hBEEF, 16'h0, 16'h0);
      tbl[8]  = mk(2, 7, 8,  'h7E, 1'b0, 3, 16'h11, 16'h22, 16'h33);
      tbl[9]  = mk(2, 7, 8,  'h7E, 1'b1, 3, 16'h11, 16'h22, 16'h33);
      tbl[10] = mk(2, 7, 8,  'h2A, 1'b0, 1, 16'hA5, 16'h0, 16'h0);
      tbl[11] = mk(2, 7, 8,  'h2A, 1'b1, 1, 16'hA5, 16'h0, 16'h0);

      wclk(3);
      chk("rst_miso", miso_v, 3'b000);
      chk("rst_oe", oe_v, 3'b000);
      chk("rst_done", done_v, 3'b000);
      chk("rst_state", u0.state_q, 0);
      rst_n = 1'b1;
      wclk(2 * PH);

      for (int t = 0; t < 12; t++) run_vec(tbl[t], $sformatf("vec%0d", t));

      // partial write word: frame still reached data so frame_done pulses, but no write
      d0 = done_cnt[0];
      cs_v[0] = 1'b0;
      wclk(PH);
      for (int i = 6; i >= 0; i--) bit_xfer(0, 1'(7'h05 >> i), r, oe);
      bit_xfer(0, 1'b0, r, oe);
      for (int i = 0; i < 5; i++) bit_xfer(0, 1'b1, r, oe);
      wclk(PH);
      cs_v[0] = 1'b1;
      wclk(2 * PH);
      chk("partial_done", done_cnt[0] - d0, 1);
      run_vec(mk(0, 7, 8, 'h05, 1'b1, 1, 16'h3C, 16'h0, 16'h0), "partial_keep");

      // abort inside the address field
      d0 = done_cnt[0];
      cs_v[0] = 1'b0;
      wclk(PH);
      for (int i = 0; i < 4; i++) bit_xfer(0, 1'b1, r, oe);
      wclk(PH);
      cs_v[0] = 1'b1;
      wclk(2 * PH);
      chk("abort_done", done_cnt[0] - d0, 0);
      run_vec(mk(0, 7, 8, 'h2A, 1'b1, 1, 16'hA5, 16'h0, 16'h0), "abort_recover");

      // reset during bit 3 of a read
      cs_v[0] = 1'b0;
      wclk(PH);
      for (int i = 6; i >= 0; i--) bit_xfer(0, 1'(7'h2A >> i), r, oe);
      bit_xfer(0, 1'b1, r, oe);
      for (int i = 2; i >= 0; i--) begin
         bit_xfer(0, 1'b0, r, oe);
         part[i] = r;
      end
      chk("rstmid_first_bits", part, 3'b101);
      mosi_v[0] = 1'b0;
      wclk(PH);
      sclk_v[0] = 1'b1;
      wclk(2);
      rst_n = 1'b0;
      #1;
      chk("rstmid_miso", miso0, 1'b0);
      chk("rstmid_oe", oe0, 1'b0);
      chk("rstmid_state", u0.state_q, 0);
      wclk(3);
      sclk_v[0] = 1'b0;
      rst_n = 1'b1;
      // cs still low after reset: clocking sclk must not start a frame
      for (int i = 0; i < 3; i++) bit_xfer(0, 1'b1, r, oe);
      wclk(PH);
      chk("rstlow_state", u0.state_q, 0);
      chk("rstlow_oe", oe0, 1'b0);
      cs_v[0] = 1'b1;
      wclk(2 * PH);
      run_vec(mk(0, 7, 8, 'h2A, 1'b1, 1, 16'hA5, 16'h0, 16'h0), "rst_recover");
      run_vec(mk(0, 7, 8, 'h7E, 1'b1, 3, 16'h11, 16'h22, 16'h33), "rst_burst");

      chk("oe_while_cs_high", oe_viol, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule
